// File: rtl/sar_guess_fsm.sv
// Binary-search initiator for a signed comparator: drives guesses on B, reads E/X/Y
// verdicts, and converges on the hidden A operand or flags an inconsistent comparator.
module sar_guess_fsm #(
    parameter int W      = 4,
    parameter int STEP_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_eq,
    input  logic              i_gt,
    input  logic              i_lt,
    output logic [W-1:0]      o_guess,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [W-1:0]      o_result,
    output logic [STEP_W-1:0] o_steps
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PROBE,
        S_EVAL,
        S_DONE,
        S_ERR
    } state_t;

    // Bounds are kept one bit wider than the operand so lo+hi and guess+/-1 never overflow.
    localparam logic signed [W:0] LO_INIT  = {2'b11, {(W-1){1'b0}}};
    localparam logic signed [W:0] HI_INIT  = {2'b00, {(W-1){1'b1}}};
    localparam logic signed [W:0] MID_INIT = (LO_INIT + HI_INIT) >>> 1;
    localparam logic signed [W:0] ONE      = {{W{1'b0}}, 1'b1};
    localparam logic [STEP_W-1:0] STEP_ONE = {{(STEP_W-1){1'b0}}, 1'b1};

    state_t              r_state;
    logic signed [W:0]   r_lo;
    logic signed [W:0]   r_hi;
    logic signed [W:0]   r_guess;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic [W-1:0]        r_result;
    logic [STEP_W-1:0]   r_steps;

    logic signed [W:0]   w_lo_inc;
    logic signed [W:0]   w_hi_dec;
    logic signed [W:0]   w_sum_gt;
    logic signed [W:0]   w_sum_lt;
    logic signed [W:0]   w_mid_gt;
    logic signed [W:0]   w_mid_lt;
    logic                w_launch;

    assign w_lo_inc = r_guess + ONE;
    assign w_hi_dec = r_guess - ONE;
    assign w_sum_gt = w_lo_inc + r_hi;
    assign w_sum_lt = r_lo + w_hi_dec;
    assign w_mid_gt = w_sum_gt >>> 1;
    assign w_mid_lt = w_sum_lt >>> 1;

    assign w_launch = i_start &&
                      ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_lo     <= '0;
            r_hi     <= '0;
            r_guess  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_result <= '0;
            r_steps  <= '0;
        end else if (w_launch) begin
            r_lo    <= LO_INIT;
            r_hi    <= HI_INIT;
            r_guess <= MID_INIT;
            r_steps <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_state <= S_PROBE;
        end else begin
            case (r_state)
                S_PROBE: r_state <= S_EVAL;
                S_EVAL: begin
                    r_steps <= r_steps + STEP_ONE;
                    case ({i_eq, i_gt, i_lt})
                        3'b100: begin
                            r_result <= r_guess[W-1:0];
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end
                        3'b010: begin
                            r_lo <= w_lo_inc;
                            if (w_lo_inc > r_hi) begin
                                r_result <= '0;
                                r_busy   <= 1'b0;
                                r_err    <= 1'b1;
                                r_state  <= S_ERR;
                            end else begin
                                r_guess <= w_mid_gt;
                                r_state <= S_PROBE;
                            end
                        end
                        3'b001: begin
                            r_hi <= w_hi_dec;
                            if (r_lo > w_hi_dec) begin
                                r_result <= '0;
                                r_busy   <= 1'b0;
                                r_err    <= 1'b1;
                                r_state  <= S_ERR;
                            end else begin
                                r_guess <= w_mid_lt;
                                r_state <= S_PROBE;
                            end
                        end
                        default: begin
                            r_result <= '0;
                            r_busy   <= 1'b0;
                            r_err    <= 1'b1;
                            r_state  <= S_ERR;
                        end
                    endcase
                end
                S_IDLE, S_DONE, S_ERR: r_state <= r_state;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_guess  = r_guess[W-1:0];
    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_err    = r_err;
    assign o_result = r_result;
    assign o_steps  = r_steps;

endmodule

// File: tb/tb_sar_guess_fsm.sv
// Pairs sar_guess_fsm with a behavioural signed comparator and checks guess sequences,
// verdicts, step counts and latency against a queue of expected results.
module tb_sar_guess_fsm;

    typedef struct {
        logic [3:0] res;
        logic [2:0] steps;
        logic       done;
        logic       err;
        int         cycles;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic signed [3:0] target;
    logic              force_flags;
    logic [3:0]        guess;
    logic              busy, done, err;
    logic [3:0]        result;
    logic [2:0]        steps;
    logic              eq_in, gt_in, lt_in;

    int tests = 0;
    int fails = 0;

    exp_t       exp_q[$];
    logic [3:0] guess_q[$];

    always #5 clk = ~clk;

    // Comparator: A = target, B = guess; force mode drives an illegal eq+gt verdict.
    assign eq_in = force_flags ? 1'b1 : (target == $signed(guess));
    assign gt_in = force_flags ? 1'b1 : (target >  $signed(guess));
    assign lt_in = force_flags ? 1'b0 : (target <  $signed(guess));

    sar_guess_fsm #(.W(4), .STEP_W(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_start  (start),
        .i_eq     (eq_in),
        .i_gt     (gt_in),
        .i_lt     (lt_in),
        .o_guess  (guess),
        .o_busy   (busy),
        .o_done   (done),
        .o_err    (err),
        .o_result (result),
        .o_steps  (steps)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic void expect_search(input logic [3:0] res, input logic [2:0] st,
                                          input logic dn, input logic er, input int cyc);
        exp_t e;
        e.res = res; e.steps = st; e.done = dn; e.err = er; e.cycles = cyc;
        exp_q.push_back(e);
    endfunction

    // Pulses start; k counts edges after the sampling edge. Probe n is evaluated at k=2n,
    // so its guess is checked at odd k and done/err must rise at k = 2*N.
    task automatic run_search(input string name, input logic frc,
                              input int chg_k, input logic signed [3:0] new_t);
        int   k;
        bit   fin;
        exp_t e;
        @(negedge clk);
        start       = 1'b1;
        force_flags = frc;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({name, "/launch_busy"}, {31'd0, busy}, 32'd1);
        chk({name, "/launch_done"}, {31'd0, done}, 32'd0);
        fin = 1'b0;
        k   = 0;
        while (!fin && k < 40) begin
            @(posedge clk);
            #1;
            k++;
            if (done || err) begin
                fin = 1'b1;
            end else begin
                if (k == chg_k) target = new_t;
                if (k % 2 == 1) begin
                    tests++;
                    assert (guess_q.size() > 0) else begin
                        fails++;
                        $error("FAIL %s/guess_extra: observed guess %0h expected no further probe", name, guess);
                    end
                    if (guess_q.size() > 0)
                        chk({name, "/guess"}, {28'd0, guess}, {28'd0, guess_q.pop_front()});
                    chk({name, "/busy"}, {31'd0, busy}, 32'd1);
                end
            end
        end
        tests++;
        assert (fin) else begin
            fails++;
            $error("FAIL %s/timeout: observed no done/err after %0d edges expected completion", name, k);
        end
        force_flags = 1'b0;
        e = exp_q.pop_front();
        chk({name, "/result"}, {28'd0, result}, {28'd0, e.res});
        chk({name, "/steps"},  {29'd0, steps},  {29'd0, e.steps});
        chk({name, "/done"},   {31'd0, done},   {31'd0, e.done});
        chk({name, "/err"},    {31'd0, err},    {31'd0, e.err});
        chk({name, "/busy_end"}, {31'd0, busy}, 32'd0);
        chk({name, "/latency"}, k, e.cycles);
        chk({name, "/probes_left"}, guess_q.size(), 32'd0);
        $display("[TB] %s: result=%0h steps=%0d done=%0b err=%0b edges=%0d", name, result, steps, done, err, k);
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        target      = 4'sd0;
        force_flags = 1'b0;
        #12;
        chk("reset/guess",  {28'd0, guess},  32'd0);
        chk("reset/busy",   {31'd0, busy},   32'd0);
        chk("reset/done",   {31'd0, done},   32'd0);
        chk("reset/err",    {31'd0, err},    32'd0);
        chk("reset/result", {28'd0, result}, 32'd0);
        chk("reset/steps",  {29'd0, steps},  32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 1: target 5
        target = 4'sd5;
        guess_q.push_back(4'hF); guess_q.push_back(4'h3); guess_q.push_back(4'h5);
        expect_search(4'h5, 3'd3, 1'b1, 1'b0, 6);
        run_search("t1_target5", 1'b0, -1, 4'sd0);
        repeat (2) @(posedge clk);
        #1;
        chk("t1/hold_done",   {31'd0, done},   32'd1);
        chk("t1/hold_result", {28'd0, result}, 32'd5);
        chk("t1/hold_guess",  {28'd0, guess},  32'd5);

        // 2: target -8, lowest value
        target = -4'sd8;
        guess_q.push_back(4'hF); guess_q.push_back(4'hB);
        guess_q.push_back(4'h9); guess_q.push_back(4'h8);
        expect_search(4'h8, 3'd4, 1'b1, 1'b0, 8);
        run_search("t2_target-8", 1'b0, -1, 4'sd0);

        // 3: target 7, worst case of five probes
        target = 4'sd7;
        guess_q.push_back(4'hF); guess_q.push_back(4'h3); guess_q.push_back(4'h5);
        guess_q.push_back(4'h6); guess_q.push_back(4'h7);
        expect_search(4'h7, 3'd5, 1'b1, 1'b0, 10);
        run_search("t3_target7", 1'b0, -1, 4'sd0);

        // 4: target -1 found on the first probe, then relaunch from DONE with target 2
        target = -4'sd1;
        guess_q.push_back(4'hF);
        expect_search(4'hF, 3'd1, 1'b1, 1'b0, 2);
        run_search("t4a_target-1", 1'b0, -1, 4'sd0);
        target = 4'sd2;
        guess_q.push_back(4'hF); guess_q.push_back(4'h3);
        guess_q.push_back(4'h1); guess_q.push_back(4'h2);
        expect_search(4'h2, 3'd4, 1'b1, 1'b0, 8);
        run_search("t4b_target2", 1'b0, -1, 4'sd0);

        // 5a: eq and gt together in the first evaluation
        target = 4'sd4;
        guess_q.push_back(4'hF);
        expect_search(4'h0, 3'd1, 1'b0, 1'b1, 2);
        run_search("t5a_badflags", 1'b1, -1, 4'sd0);

        // 5b: target 4 moves to -3 after the first gt verdict, bounds cross
        target = 4'sd4;
        guess_q.push_back(4'hF); guess_q.push_back(4'h3);
        guess_q.push_back(4'h1); guess_q.push_back(4'h0);
        expect_search(4'h0, 3'd4, 1'b0, 1'b1, 8);
        run_search("t5b_moved", 1'b0, 2, -4'sd3);
        chk("t5b/hold_guess", {28'd0, guess}, 32'd0);

        // 6: asynchronous reset while in PROBE
        target = 4'sd5;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("t6/probe_busy", {31'd0, busy}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6/rst_guess",  {28'd0, guess},  32'd0);
        chk("t6/rst_busy",   {31'd0, busy},   32'd0);
        chk("t6/rst_done",   {31'd0, done},   32'd0);
        chk("t6/rst_err",    {31'd0, err},    32'd0);
        chk("t6/rst_result", {28'd0, result}, 32'd0);
        chk("t6/rst_steps",  {29'd0, steps},  32'd0);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("t6/start_ignored_busy",  {31'd0, busy},  32'd0);
        chk("t6/start_ignored_guess", {28'd0, guess}, 32'd0);
        guess_q.push_back(4'hF); guess_q.push_back(4'h3); guess_q.push_back(4'h5);
        expect_search(4'h5, 3'd3, 1'b1, 1'b0, 6);
        run_search("t6_after_reset", 1'b0, -1, 4'sd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
